alu_writeback: RTL and testbench

Result-commit stage directly downstream of the ALU. It holds the current-result accumulator and the carry and borrow flags that feed back into the ALU carry and borrow inputs. It executes ST/STN/S/R destination writes to the register file directly, and to bit or word memory through a req/ack handshake. Store ops that hit memory stall the issuing sequencer through in_ready.

---
 rtl/alu_writeback.sv | 178 +++++++++++++++++
 tb/tb_alu_writeback.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: result-commit stage behind the ALU.
// Holds the accumulator and the carry/borrow flags fed back to the ALU, and
// commits store ops to the register file (single-cycle strobe) or to bit/word
// memory (req/ack handshake that stalls the sequencer through in_ready).
module alu_writeback #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned IWIDTH     = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IWIDTH-1:0]     op_code,
    input  logic [1:0]            dest_sel,
    input  logic [ADDR_WIDTH-1:0] dest_addr,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_c_out,
    input  logic                  alu_b_out,
    input  logic                  alu_flag_valid,
    output logic [WIDTH-1:0]      acc,
    output logic                  carry_flag,
    output logic                  borrow_flag,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic                  mem_req,
    output logic                  mem_is_bit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack
);

    // Shared opcode encodings (must match the ALU decoder).
    localparam logic [IWIDTH-1:0] OpAdd = IWIDTH'(8'h01);
    localparam logic [IWIDTH-1:0] OpSub = IWIDTH'(8'h02);
    localparam logic [IWIDTH-1:0] OpSt  = IWIDTH'(8'h08);
    localparam logic [IWIDTH-1:0] OpStn = IWIDTH'(8'h09);
    localparam logic [IWIDTH-1:0] OpS   = IWIDTH'(8'h0A);
    localparam logic [IWIDTH-1:0] OpR   = IWIDTH'(8'h0B);

    localparam logic [1:0] DestRf   = 2'b00;
    localparam logic [1:0] DestBit  = 2'b01;
    localparam logic [1:0] DestWord = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StMemWait
    } state_t;

    state_t                r_state, w_state_d;
    logic [WIDTH-1:0]      r_acc, w_acc_d;
    logic                  r_carry, w_carry_d;
    logic                  r_borrow, w_borrow_d;
    logic                  r_rf_we, w_rf_we_d;
    logic [ADDR_WIDTH-1:0] r_rf_waddr, w_rf_waddr_d;
    logic [WIDTH-1:0]      r_rf_wdata, w_rf_wdata_d;
    logic                  r_mem_req, w_mem_req_d;
    logic                  r_mem_is_bit, w_mem_is_bit_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_d;
    logic [WIDTH-1:0]      r_mem_wdata, w_mem_wdata_d;

    logic w_accept;
    logic w_is_store;
    logic w_is_cond;
    logic w_do_write;

    // Instruction classification; anything not a store is an accumulator op.
    always_comb begin
        w_accept   = in_valid && (r_state == StIdle);
        w_is_store = (op_code == OpSt) || (op_code == OpStn) ||
                     (op_code == OpS)  || (op_code == OpR);
        w_is_cond  = (op_code == OpS) || (op_code == OpR);
        // S/R only write when the current result bit is set.
        w_do_write = w_is_store && (!w_is_cond || r_acc[0]);
    end

    // Next-state decode for the FSM and all committed registers.
    always_comb begin
        w_state_d       = r_state;
        w_acc_d         = r_acc;
        w_carry_d       = r_carry;
        w_borrow_d      = r_borrow;
        w_rf_we_d       = 1'b0;
        w_rf_waddr_d    = r_rf_waddr;
        w_rf_wdata_d    = r_rf_wdata;
        w_mem_req_d     = r_mem_req;
        w_mem_is_bit_d  = r_mem_is_bit;
        w_mem_addr_d    = r_mem_addr;
        w_mem_wdata_d   = r_mem_wdata;

        unique case (r_state)
            StIdle: begin
                if (w_accept && !w_is_store) begin
                    w_acc_d = alu_out;
                    if (alu_flag_valid && (op_code == OpAdd)) begin
                        w_carry_d = alu_c_out;
                    end
                    if (alu_flag_valid && (op_code == OpSub)) begin
                        w_borrow_d = alu_b_out;
                    end
                end else if (w_accept && w_do_write) begin
                    if (dest_sel == DestRf) begin
                        w_rf_we_d    = 1'b1;
                        w_rf_waddr_d = dest_addr;
                        w_rf_wdata_d = alu_out;
                    end else if ((dest_sel == DestBit) || (dest_sel == DestWord)) begin
                        w_state_d      = StMemWait;
                        w_mem_req_d    = 1'b1;
                        w_mem_addr_d   = dest_addr;
                        w_mem_is_bit_d = (dest_sel == DestBit);
                        if (dest_sel == DestBit) begin
                            w_mem_wdata_d = {{(WIDTH-1){1'b0}}, alu_out[0]};
                        end else begin
                            w_mem_wdata_d = alu_out;
                        end
                    end
                end
            end
            StMemWait: begin
                // Request fields stay frozen until the memory takes the write.
                if (mem_ack && r_mem_req) begin
                    w_mem_req_d = 1'b0;
                    w_state_d   = StIdle;
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_mem_req_d = 1'b0;
            end
        endcase
    end

    // State registers; synchronous reset abandons any in-flight memory write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_borrow     <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_is_bit <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_acc        <= w_acc_d;
            r_carry      <= w_carry_d;
            r_borrow     <= w_borrow_d;
            r_rf_we      <= w_rf_we_d;
            r_rf_waddr   <= w_rf_waddr_d;
            r_rf_wdata   <= w_rf_wdata_d;
            r_mem_req    <= w_mem_req_d;
            r_mem_is_bit <= w_mem_is_bit_d;
            r_mem_addr   <= w_mem_addr_d;
            r_mem_wdata  <= w_mem_wdata_d;
        end
    end

    // Output mapping; in_ready is a pure decode of the state.
    always_comb begin
        in_ready    = (r_state == StIdle);
        acc         = r_acc;
        carry_flag  = r_carry;
        borrow_flag = r_borrow;
        rf_we       = r_rf_we;
        rf_waddr    = r_rf_waddr;
        rf_wdata    = r_rf_wdata;
        mem_req     = r_mem_req;
        mem_is_bit  = r_mem_is_bit;
        mem_addr    = r_mem_addr;
        mem_wdata   = r_mem_wdata;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: accumulator/flag updates, register-file
// strobes, memory handshake with stall, conditional S/R, reset mid-transfer.
module tb_alu_writeback;

    localparam logic [7:0] OpAdd = 8'h01;
    localparam logic [7:0] OpSub = 8'h02;
    localparam logic [7:0] OpAnd = 8'h03;
    localparam logic [7:0] OpSt  = 8'h08;
    localparam logic [7:0] OpStn = 8'h09;
    localparam logic [7:0] OpS   = 8'h0A;
    localparam logic [7:0] OpR   = 8'h0B;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_code;
    logic [1:0] dest_sel;
    logic [7:0] dest_addr;
    logic [7:0] alu_out;
    logic       alu_c_out;
    logic       alu_b_out;
    logic       alu_flag_valid;
    logic [7:0] acc;
    logic       carry_flag;
    logic       borrow_flag;
    logic       rf_we;
    logic [7:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       mem_req;
    logic       mem_is_bit;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;

    int n_total = 0;
    int n_pass  = 0;

    alu_writeback #(
        .WIDTH      (8),
        .IWIDTH     (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_code        (op_code),
        .dest_sel       (dest_sel),
        .dest_addr      (dest_addr),
        .alu_out        (alu_out),
        .alu_c_out      (alu_c_out),
        .alu_b_out      (alu_b_out),
        .alu_flag_valid (alu_flag_valid),
        .acc            (acc),
        .carry_flag     (carry_flag),
        .borrow_flag    (borrow_flag),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .mem_req        (mem_req),
        .mem_is_bit     (mem_is_bit),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [1:0] ds,
                         input logic [7:0] da, input logic [7:0] ao,
                         input logic c, input logic b, input logic fv);
        in_valid       = v;
        op_code        = op;
        dest_sel       = ds;
        dest_addr      = da;
        alu_out        = ao;
        alu_c_out      = c;
        alu_b_out      = b;
        alu_flag_valid = fv;
    endtask

    initial begin
        rst     = 1'b1;
        mem_ack = 1'b0;
        drive(1'b0, 8'h00, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_acc", acc, 8'h00);
        chk("rst_carry", {7'd0, carry_flag}, 8'h00);
        chk("rst_borrow", {7'd0, borrow_flag}, 8'h00);
        chk("rst_rf_we", {7'd0, rf_we}, 8'h00);
        chk("rst_mem_req", {7'd0, mem_req}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        chk("rst_rf_waddr", rf_waddr, 8'h00);
        chk("rst_mem_addr", mem_addr, 8'h00);

        // Accumulator ops and flags
        drive(1'b1, OpAdd, 2'b00, 8'h03, 8'h34, 1'b1, 1'b0, 1'b1);
        tick();
        chk("add_acc", acc, 8'h34);
        chk("add_carry", {7'd0, carry_flag}, 8'h01);
        chk("add_no_rf_we", {7'd0, rf_we}, 8'h00);
        drive(1'b1, OpAnd, 2'b00, 8'h03, 8'h0F, 1'b0, 1'b1, 1'b0);
        tick();
        chk("and_acc", acc, 8'h0F);
        chk("and_carry_hold", {7'd0, carry_flag}, 8'h01);
        chk("and_borrow_hold", {7'd0, borrow_flag}, 8'h00);
        drive(1'b1, OpSub, 2'b00, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b1);
        tick();
        chk("sub_acc", acc, 8'hFE);
        chk("sub_borrow", {7'd0, borrow_flag}, 8'h01);
        chk("sub_carry_hold", {7'd0, carry_flag}, 8'h01);
        drive(1'b1, OpAdd, 2'b00, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add_nofv_carry", {7'd0, carry_flag}, 8'h01);
        drive(1'b1, 8'hFF, 2'b01, 8'h44, 8'h10, 1'b0, 1'b0, 1'b1);
        tick();
        chk("undef_acc", acc, 8'h10);
        chk("undef_no_mem", {7'd0, mem_req}, 8'h00);
        chk("undef_borrow_hold", {7'd0, borrow_flag}, 8'h01);

        // Register-file store, then back-to-back stores
        drive(1'b1, OpSt, 2'b00, 8'h05, 8'hA5, 1'b1, 1'b1, 1'b1);
        tick();
        chk("st_rf_we", {7'd0, rf_we}, 8'h01);
        chk("st_rf_waddr", rf_waddr, 8'h05);
        chk("st_rf_wdata", rf_wdata, 8'hA5);
        chk("st_acc_hold", acc, 8'h10);
        chk("st_carry_hold", {7'd0, carry_flag}, 8'h01);
        chk("st_in_ready", {7'd0, in_ready}, 8'h01);
        drive(1'b0, OpSt, 2'b00, 8'h09, 8'h99, 1'b0, 1'b0, 1'b0);
        tick();
        chk("st_rf_we_drop", {7'd0, rf_we}, 8'h00);
        chk("st_rf_waddr_hold", rf_waddr, 8'h05);
        chk("st_rf_wdata_hold", rf_wdata, 8'hA5);
        drive(1'b1, OpSt, 2'b00, 8'h06, 8'h11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b1_addr", rf_waddr, 8'h06);
        drive(1'b1, OpStn, 2'b00, 8'h07, 8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b2_we", {7'd0, rf_we}, 8'h01);
        chk("b2b2_addr", rf_waddr, 8'h07);
        chk("b2b2_data", rf_wdata, 8'h22);

        // Word-memory store with ack after 3 cycles of request
        drive(1'b1, OpSt, 2'b10, 8'h20, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mw_req_c1", {7'd0, mem_req}, 8'h01);
        chk("mw_addr_c1", mem_addr, 8'h20);
        chk("mw_data_c1", mem_wdata, 8'h5A);
        chk("mw_isbit_c1", {7'd0, mem_is_bit}, 8'h00);
        chk("mw_ready_c1", {7'd0, in_ready}, 8'h00);
        chk("mw_rf_we_c1", {7'd0, rf_we}, 8'h00);
        // This instruction must be ignored while stalled.
        drive(1'b1, OpAdd, 2'b00, 8'h09, 8'h99, 1'b0, 1'b0, 1'b1);
        tick();
        chk("mw_req_c2", {7'd0, mem_req}, 8'h01);
        chk("mw_addr_c2", mem_addr, 8'h20);
        chk("mw_acc_c2", acc, 8'h10);
        chk("mw_carry_c2", {7'd0, carry_flag}, 8'h01);
        tick();
        chk("mw_req_c3", {7'd0, mem_req}, 8'h01);
        chk("mw_data_c3", mem_wdata, 8'h5A);
        chk("mw_ready_c3", {7'd0, in_ready}, 8'h00);
        mem_ack = 1'b1;
        tick();
        chk("mw_req_done", {7'd0, mem_req}, 8'h00);
        chk("mw_ready_done", {7'd0, in_ready}, 8'h01);
        chk("mw_acc_ignored", acc, 8'h10);
        chk("mw_rf_we_ignored", {7'd0, rf_we}, 8'h00);
        drive(1'b0, OpAdd, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_ack_ignored", {7'd0, mem_req}, 8'h00);
        mem_ack = 1'b0;

        // Conditional S to bit memory
        drive(1'b1, OpAnd, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OpS, 2'b01, 8'h30, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s0_no_mem", {7'd0, mem_req}, 8'h00);
        chk("s0_no_rf", {7'd0, rf_we}, 8'h00);
        chk("s0_ready", {7'd0, in_ready}, 8'h01);
        drive(1'b1, OpAnd, 2'b00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OpS, 2'b01, 8'h30, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s1_mem_req", {7'd0, mem_req}, 8'h01);
        chk("s1_is_bit", {7'd0, mem_is_bit}, 8'h01);
        chk("s1_wdata", mem_wdata, 8'h01);
        chk("s1_addr", mem_addr, 8'h30);
        drive(1'b0, OpS, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        tick();
        chk("s1_done", {7'd0, mem_req}, 8'h00);
        mem_ack = 1'b0;
        drive(1'b1, OpR, 2'b00, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("r_rf_we", {7'd0, rf_we}, 8'h01);
        chk("r_rf_addr", rf_waddr, 8'h0C);
        chk("r_rf_data", rf_wdata, 8'h00);
        drive(1'b1, OpStn, 2'b11, 8'h0D, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        chk("nodest_rf", {7'd0, rf_we}, 8'h00);
        chk("nodest_mem", {7'd0, mem_req}, 8'h00);
        chk("nodest_acc", acc, 8'h01);

        // Reset during MEM_WAIT
        drive(1'b1, OpAnd, 2'b00, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OpSt, 2'b10, 8'h40, 8'h33, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rw_req", {7'd0, mem_req}, 8'h01);
        chk("rw_acc", acc, 8'h77);
        drive(1'b0, OpAdd, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req_cleared", {7'd0, mem_req}, 8'h00);
        chk("rw_acc_cleared", acc, 8'h00);
        chk("rw_ready", {7'd0, in_ready}, 8'h01);
        chk("rw_carry_cleared", {7'd0, carry_flag}, 8'h00);
        chk("rw_addr_cleared", mem_addr, 8'h00);
        mem_ack = 1'b1;
        tick();
        chk("late_ack_req", {7'd0, mem_req}, 8'h00);
        chk("late_ack_ready", {7'd0, in_ready}, 8'h01);
        chk("late_ack_acc", acc, 8'h00);
        mem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
